// File: rtl/spi_slave.sv
`timescale 1ns/1ps
// spi_slave: mode-3 (CPOL=1, CPHA=1) SPI slave, oversampled by sys_clk.
// The SPI pins are synchronised with two flops and edge-detected with a third;
// every pin-driven register update lands two sys_clk edges after capture.
// Received bytes come out as one-cycle strobes. Transmit bytes go through a
// one-deep holding register, and 8'hFF is sent when that register is empty.
module spi_slave #(
    parameter logic IDLE_MISO = 1'b1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       spi_cs_n_i,
    input  logic       spi_sck_i,
    input  logic       spi_mosi_i,
    output logic       spi_miso_o,
    output logic       spi_miso_oe_o,
    input  logic       tx_valid_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_ready_o,
    output logic       tx_underrun_o,
    output logic       rx_valid_o,
    output logic [7:0] rx_data_o,
    output logic       frame_start_o,
    output logic       frame_end_o,
    output logic       busy_o
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t     state;
    logic       cs_s1, cs_s2, cs_d;
    logic       sck_s1, sck_s2, sck_d;
    logic       mosi_s1, mosi_s2;
    logic [2:0] bit_cnt;
    logic       hold_full;
    logic [7:0] hold_data;
    // Only the 7 bits still to be sent are kept; bit 7 goes straight to MISO on load.
    logic [6:0] tx_shift;
    // The 7 most recent bits; the 8th bit is taken directly from mosi_s2.
    logic [6:0] rx_shift;
    logic       cs_fall, cs_rise, sck_fall, sck_rise, tx_accept;
    logic [7:0] tx_load;

    // Pin synchronisers plus a delay stage on cs and sck for edge detection
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            cs_d    <= 1'b1;
            sck_s1  <= 1'b1;
            sck_s2  <= 1'b1;
            sck_d   <= 1'b1;
            mosi_s1 <= 1'b1;
            mosi_s2 <= 1'b1;
        end else begin
            cs_s1   <= spi_cs_n_i;
            cs_s2   <= cs_s1;
            cs_d    <= cs_s2;
            sck_s1  <= spi_sck_i;
            sck_s2  <= sck_s1;
            sck_d   <= sck_s2;
            mosi_s1 <= spi_mosi_i;
            mosi_s2 <= mosi_s1;
        end
    end

    // Edge strobes; SCK edges only count while the synchronised chip select is low
    always_comb begin
        cs_fall    = ~cs_s2 & cs_d;
        cs_rise    = cs_s2 & ~cs_d;
        sck_rise   = sck_s2 & ~sck_d & ~cs_s2;
        sck_fall   = ~sck_s2 & sck_d & ~cs_s2;
        tx_accept  = tx_valid_i & ~hold_full;
        tx_load    = hold_full ? hold_data : 8'hFF;
        tx_ready_o = ~hold_full;
    end

    // Control FSM: frame tracking, bit counting, MISO drive, holding flag and strobes
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= IDLE;
            bit_cnt       <= 3'd0;
            hold_full     <= 1'b0;
            spi_miso_o    <= IDLE_MISO;
            spi_miso_oe_o <= 1'b0;
            busy_o        <= 1'b0;
            rx_data_o     <= 8'h00;
            rx_valid_o    <= 1'b0;
            tx_underrun_o <= 1'b0;
            frame_start_o <= 1'b0;
            frame_end_o   <= 1'b0;
        end else begin
            frame_start_o <= 1'b0;
            frame_end_o   <= 1'b0;
            rx_valid_o    <= 1'b0;
            tx_underrun_o <= 1'b0;
            if (tx_accept) begin
                hold_full <= 1'b1;
            end
            case (state)
                IDLE: begin
                    bit_cnt    <= 3'd0;
                    spi_miso_o <= IDLE_MISO;
                    if (cs_fall) begin
                        state         <= ACTIVE;
                        frame_start_o <= 1'b1;
                        busy_o        <= 1'b1;
                        spi_miso_oe_o <= 1'b1;
                    end
                end
                ACTIVE: begin
                    // A partial byte is dropped; the holding register is left alone.
                    if (cs_rise) begin
                        state         <= IDLE;
                        frame_end_o   <= 1'b1;
                        busy_o        <= 1'b0;
                        spi_miso_oe_o <= 1'b0;
                        bit_cnt       <= 3'd0;
                        spi_miso_o    <= IDLE_MISO;
                    end
                end
                default: state <= IDLE;
            endcase
            if (sck_fall) begin
                if (bit_cnt == 3'd0) begin
                    // A write in this same cycle is not visible yet, so it waits for the next byte.
                    spi_miso_o <= tx_load[7];
                    if (hold_full) begin
                        hold_full <= 1'b0;
                    end else begin
                        tx_underrun_o <= 1'b1;
                    end
                end else begin
                    spi_miso_o <= tx_shift[6];
                end
            end
            if (sck_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx_valid_o <= 1'b1;
                    rx_data_o  <= {rx_shift, mosi_s2};
                end
            end
        end
    end

    // Data registers: holding byte, TX shifter and RX shifter (no reset needed)
    always_ff @(posedge sys_clk) begin
        if (tx_accept) begin
            hold_data <= tx_data_i;
        end
        if (sck_fall) begin
            if (bit_cnt == 3'd0) begin
                tx_shift <= tx_load[6:0];
            end else begin
                tx_shift <= {tx_shift[5:0], 1'b0};
            end
        end
        if (sck_rise) begin
            rx_shift <= {rx_shift[5:0], mosi_s2};
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps
// tb_spi_slave: directed and randomised SPI frames against a one-slot
// holding-register model of the slave.
module tb_spi_slave;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       cs_n = 1'b1;
    logic       sck = 1'b1;
    logic       mosi = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       spi_miso_o, spi_miso_oe_o, tx_ready_o, tx_underrun_o;
    logic       rx_valid_o, frame_start_o, frame_end_o, busy_o;
    logic [7:0] rx_data_o;

    int total = 0;
    int bad = 0;
    // Number of sys_clk cycles each strobe was seen high
    int rx_cnt = 0;
    int ur_cnt = 0;
    int fs_cnt = 0;
    int fe_cnt = 0;

    // Reference model: a single holding slot plus the last complete received byte
    logic       m_full = 1'b0;
    logic [7:0] m_hold = 8'h00;
    logic [7:0] exp_rx_last = 8'h00;

    // Per-frame stimulus: MOSI byte, load mode (0 none, 1 mid-byte, 2 same cycle as start), load byte
    logic [7:0] f_mo [3];
    int         f_mode [3];
    logic [7:0] f_ld [3];

    spi_slave dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .spi_cs_n_i    (cs_n),
        .spi_sck_i     (sck),
        .spi_mosi_i    (mosi),
        .spi_miso_o    (spi_miso_o),
        .spi_miso_oe_o (spi_miso_oe_o),
        .tx_valid_i    (tx_valid),
        .tx_data_i     (tx_data),
        .tx_ready_o    (tx_ready_o),
        .tx_underrun_o (tx_underrun_o),
        .rx_valid_o    (rx_valid_o),
        .rx_data_o     (rx_data_o),
        .frame_start_o (frame_start_o),
        .frame_end_o   (frame_end_o),
        .busy_o        (busy_o)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (rx_valid_o)    rx_cnt = rx_cnt + 1;
            if (tx_underrun_o) ur_cnt = ur_cnt + 1;
            if (frame_start_o) fs_cnt = fs_cnt + 1;
            if (frame_end_o)   fe_cnt = fe_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_miso"}, spi_miso_o, 1);
        chk({tag, "_rx_data"}, rx_data_o, 0);
        chk({tag, "_oe"}, spi_miso_oe_o, 0);
        chk({tag, "_underrun"}, tx_underrun_o, 0);
        chk({tag, "_rx_valid"}, rx_valid_o, 0);
        chk({tag, "_fstart"}, frame_start_o, 0);
        chk({tag, "_fend"}, frame_end_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_tx_ready"}, tx_ready_o, 1);
    endtask

    // Master side of one byte; SCK half period is 4 sys_clk cycles, MISO sampled at the rise
    task automatic xfer(input logic [7:0] mo, input int nbits, input int mode,
                        input logic [7:0] ld, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            sck  = 1'b0;
            mosi = mo[i];
            if (i == 7 && mode == 2) begin
                repeat (2) @(negedge sys_clk);
                tx_valid = 1'b1;
                tx_data  = ld;
                @(negedge sys_clk);
                tx_valid = 1'b0;
                @(negedge sys_clk);
            end else if (i == 7 && mode == 1) begin
                repeat (3) @(negedge sys_clk);
                chk("tx_ready_after_consume", tx_ready_o, 1);
                tx_valid = 1'b1;
                tx_data  = ld;
                @(negedge sys_clk);
                tx_valid = 1'b0;
            end else begin
                repeat (4) @(negedge sys_clk);
            end
            mi[i] = spi_miso_o;
            sck = 1'b1;
            repeat (4) @(negedge sys_clk);
        end
    endtask

    task automatic preload(input logic [7:0] b);
        int n = 0;
        while (!tx_ready_o && n < 50) begin
            @(negedge sys_clk);
            n++;
        end
        chk("preload_ready", tx_ready_o, 1);
        tx_valid = 1'b1;
        tx_data  = b;
        @(negedge sys_clk);
        tx_valid = 1'b0;
        chk("ready_low_after_accept", tx_ready_o, 0);
        m_full = 1'b1;
        m_hold = b;
    endtask

    task automatic run_frame(input int nb, input int last_bits);
        int rx0, ur0, fs0, fe0, exp_rx, exp_ur, bits;
        logic [7:0] mi, exp_mi;
        rx0 = rx_cnt; ur0 = ur_cnt; fs0 = fs_cnt; fe0 = fe_cnt;
        exp_rx = 0; exp_ur = 0;
        cs_n = 1'b0;
        repeat (4) @(negedge sys_clk);
        chk("busy_in_frame", busy_o, 1);
        chk("oe_in_frame", spi_miso_oe_o, 1);
        chk("miso_before_first_fall", spi_miso_o, 1);
        for (int b = 0; b < nb; b++) begin
            bits = (b == nb - 1) ? last_bits : 8;
            if (m_full) begin
                exp_mi = m_hold;
                m_full = 1'b0;
            end else begin
                exp_mi = 8'hFF;
                exp_ur++;
            end
            if (f_mode[b] != 0) begin
                m_full = 1'b1;
                m_hold = f_ld[b];
            end
            xfer(f_mo[b], bits, f_mode[b], f_ld[b], mi);
            if (bits == 8) begin
                chk("miso_byte", mi, exp_mi);
                exp_rx++;
                exp_rx_last = f_mo[b];
                chk("rx_data_byte", rx_data_o, exp_rx_last);
            end else begin
                chk("miso_partial", mi >> (8 - bits), exp_mi >> (8 - bits));
            end
        end
        cs_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        chk("rx_valid_cycles", rx_cnt - rx0, exp_rx);
        chk("underrun_cycles", ur_cnt - ur0, exp_ur);
        chk("frame_start_cycles", fs_cnt - fs0, 1);
        chk("frame_end_cycles", fe_cnt - fe0, 1);
        chk("rx_data_held", rx_data_o, exp_rx_last);
        chk("miso_idle_after_frame", spi_miso_o, 1);
        chk("busy_after_frame", busy_o, 0);
        chk("oe_after_frame", spi_miso_oe_o, 0);
        chk("tx_ready_after_frame", tx_ready_o, !m_full);
    endtask

    initial begin
        int rx0, ur0, fs0, fe0, nb;
        logic sim_full;
        logic [7:0] mi, mo2;

        // Reset values while reset is held, then release
        repeat (3) @(negedge sys_clk);
        chk_reset_values("reset");
        sys_rst_n = 1'b1;
        repeat (4) @(negedge sys_clk);

        // Preloaded byte goes out while 3C comes in
        preload(8'hA5);
        f_mo[0] = 8'h3C; f_mode[0] = 0; f_ld[0] = 8'h00;
        run_frame(1, 8);

        // No preload: all-ones on MISO with one underrun
        f_mo[0] = 8'h00; f_mode[0] = 0;
        run_frame(1, 8);

        // Three-byte frame, each next byte written during the current one
        preload(8'h01);
        f_mo[0] = 8'($urandom); f_mode[0] = 1; f_ld[0] = 8'h02;
        f_mo[1] = 8'($urandom); f_mode[1] = 1; f_ld[1] = 8'h03;
        f_mo[2] = 8'($urandom); f_mode[2] = 0; f_ld[2] = 8'h00;
        run_frame(3, 8);

        // Frame aborted after 5 bits, then a complete 81
        f_mo[0] = 8'($urandom); f_mode[0] = 0;
        run_frame(1, 5);
        f_mo[0] = 8'h81; f_mode[0] = 0;
        run_frame(1, 8);

        // SCK toggling with CS high does nothing
        rx0 = rx_cnt; ur0 = ur_cnt; fs0 = fs_cnt;
        for (int k = 0; k < 6; k++) begin
            sck  = 1'b0;
            mosi = 1'($urandom);
            repeat (4) @(negedge sys_clk);
            sck = 1'b1;
            repeat (4) @(negedge sys_clk);
        end
        chk("cs_high_rx", rx_cnt - rx0, 0);
        chk("cs_high_underrun", ur_cnt - ur0, 0);
        chk("cs_high_fstart", fs_cnt - fs0, 0);
        chk("cs_high_miso", spi_miso_o, 1);
        chk("cs_high_busy", busy_o, 0);
        chk("cs_high_ready", tx_ready_o, 1);

        // Write lands in the byte-start cycle: FF now, written byte next
        f_mo[0] = 8'($urandom); f_mode[0] = 2; f_ld[0] = 8'($urandom);
        f_mo[1] = 8'($urandom); f_mode[1] = 0;
        run_frame(2, 8);

        // Reset pulse at bit 4 with the holding register full
        cs_n = 1'b0;
        repeat (4) @(negedge sys_clk);
        xfer(8'($urandom), 4, 1, 8'h5A, mi);
        chk("hold_full_before_reset", tx_ready_o, 0);
        sys_rst_n = 1'b0;
        #1;
        chk_reset_values("midframe_reset");
        m_full = 1'b0;
        exp_rx_last = 8'h00;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        rx0 = rx_cnt; ur0 = ur_cnt; fs0 = fs_cnt; fe0 = fe_cnt;
        repeat (5) @(negedge sys_clk);
        chk("restart_fstart", fs_cnt - fs0, 1);
        chk("restart_busy", busy_o, 1);
        mo2 = 8'($urandom);
        xfer(mo2, 8, 0, 8'h00, mi);
        exp_rx_last = mo2;
        chk("restart_miso", mi, 8'hFF);
        chk("restart_rx_data", rx_data_o, mo2);
        chk("restart_rx_cycles", rx_cnt - rx0, 1);
        chk("restart_underrun", ur_cnt - ur0, 1);
        cs_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        chk("restart_fend", fe_cnt - fe0, 1);

        // Randomised frames
        for (int fr = 0; fr < 6; fr++) begin
            nb = $urandom_range(1, 3);
            if (!m_full && $urandom_range(0, 1) == 1) preload(8'($urandom));
            sim_full = m_full;
            for (int b = 0; b < nb; b++) begin
                f_mo[b] = 8'($urandom);
                f_ld[b] = 8'($urandom);
                f_mode[b] = sim_full ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 2));
                sim_full = (f_mode[b] != 0);
            end
            run_frame(nb, 8);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
